// File: rtl/clock_pkg.sv
// ============================================================================
// Module   : clock_pkg
// Brief    : Shared constants, glyph table, FSM state type and BCD helpers
//            for the clock timekeeping / segment driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clock_pkg;

    // Digit slots within the segment vector, H1 is the most significant.
    localparam int NUM_DIGITS = 9;
    localparam int DIG_H1     = 8;
    localparam int DIG_H0     = 7;
    localparam int DIG_M1     = 6;
    localparam int DIG_M0     = 5;
    localparam int DIG_S1     = 4;
    localparam int DIG_S0     = 3;
    localparam int DIG_MS2    = 2;
    localparam int DIG_MS1    = 1;
    localparam int DIG_MS0    = 0;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    // Active-low glyphs {a,b,c,d,e,f,g}; entry k is the glyph for digit k.
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;
    localparam logic [9:0][6:0] GLYPH_TABLE = {
        7'b0000100,   // 9
        7'b0000000,   // 8
        7'b0001111,   // 7
        7'b0100000,   // 6
        7'b0100100,   // 5
        7'b1001100,   // 4
        7'b0000110,   // 3
        7'b0010010,   // 2
        7'b1001111,   // 1
        7'b0000001    // 0
    };

    localparam logic [7:0]  HH_MAX = 8'h23;
    localparam logic [7:0]  MM_MAX = 8'h59;
    localparam logic [7:0]  SS_MAX = 8'h59;
    localparam logic [11:0] MS_MAX = 12'h999;

    typedef enum logic [1:0] {
        ST_STOP    = 2'd0,
        ST_RUN     = 2'd1,
        ST_LOADING = 2'd2
    } clock_state_e;

    // Two-digit BCD increment with wrap at max; bit 8 is the carry out.
    function automatic logic [8:0] bcd2_inc(input logic [7:0] v, input logic [7:0] max);
        if (v == max)
            return 9'h100;
        else if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [12:0] bcd3_inc(input logic [11:0] v);
        if (v == MS_MAX)
            return 13'h1000;
        else if (v[3:0] != 4'd9)
            return {1'b0, v[11:4], v[3:0] + 4'd1};
        else if (v[7:4] != 4'd9)
            return {1'b0, v[11:8], v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[11:8] + 4'd1, 8'd0};
    endfunction

    function automatic logic bcd2_ok(input logic [7:0] v, input logic [7:0] max);
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= max);
    endfunction

endpackage

`default_nettype wire

// File: rtl/clock_seg_driver_bcd_to_seg7.sv
// ============================================================================
// Module   : bcd_to_seg7
// Brief    : Combinational 4-bit BCD to active-low seven-segment encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_seg7
    import clock_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = GLYPH_BLANK;
        case (bcd)
            4'd0: seg = GLYPH_TABLE[0];
            4'd1: seg = GLYPH_TABLE[1];
            4'd2: seg = GLYPH_TABLE[2];
            4'd3: seg = GLYPH_TABLE[3];
            4'd4: seg = GLYPH_TABLE[4];
            4'd5: seg = GLYPH_TABLE[5];
            4'd6: seg = GLYPH_TABLE[6];
            4'd7: seg = GLYPH_TABLE[7];
            4'd8: seg = GLYPH_TABLE[8];
            4'd9: seg = GLYPH_TABLE[9];
            default: seg = GLYPH_BLANK;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/clock_seg_driver.sv
// ============================================================================
// Module   : clock_seg_driver
// Brief    : HH:MM:SS.mmm BCD timekeeper with load handshake and registered
//            63-bit active-low segment output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clock_seg_driver
    import clock_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int MS_DIV = CLK_HZ / 1000
) (
    input  logic        CLK,
    input  logic        RST_BTN,
    input  logic        run,
    input  logic        clear,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [7:0]  load_hh,
    input  logic [7:0]  load_mm,
    input  logic [7:0]  load_ss,
    output logic        load_err,
    output logic        ms_tick,
    output logic        wrap,
    output logic [62:0] con
);

    localparam int                    c_PRESC_W   = (MS_DIV > 2) ? $clog2(MS_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(MS_DIV - 1);

    clock_state_e          r_state, w_next_state;
    logic [c_PRESC_W-1:0]  r_presc;
    logic [7:0]            r_hh, r_mm, r_ss;
    logic [11:0]           r_ms;
    logic                  r_load_ready, w_load_ready_next;
    logic                  r_load_err, r_ms_tick, r_wrap;
    logic [62:0]           r_con, w_con;

    logic        w_tick, w_xfer, w_load_ok, w_accept, w_reject, w_advance;
    logic [12:0] w_ms_inc;
    logic [8:0]  w_ss_inc, w_mm_inc, w_hh_inc;
    logic        w_c_ms, w_c_ss, w_c_mm, w_rollover;
    logic [8:0][3:0] w_digits;

    // clear outranks load, and both outrank the millisecond advance.
    assign w_tick    = (r_state == ST_RUN) && (r_presc == c_PRESC_MAX);
    assign w_xfer    = load_valid && r_load_ready && !clear;
    assign w_load_ok = bcd2_ok(load_hh, HH_MAX) && bcd2_ok(load_mm, MM_MAX)
                    && bcd2_ok(load_ss, SS_MAX);
    assign w_accept  = w_xfer && w_load_ok;
    assign w_reject  = w_xfer && !w_load_ok;
    assign w_advance = w_tick && !clear && !w_accept;

    assign w_ms_inc   = bcd3_inc(r_ms);
    assign w_ss_inc   = bcd2_inc(r_ss, SS_MAX);
    assign w_mm_inc   = bcd2_inc(r_mm, MM_MAX);
    assign w_hh_inc   = bcd2_inc(r_hh, HH_MAX);
    assign w_c_ms     = w_ms_inc[12];
    assign w_c_ss     = w_c_ms && w_ss_inc[8];
    assign w_c_mm     = w_c_ss && w_mm_inc[8];
    assign w_rollover = w_c_mm && w_hh_inc[8];

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN)
            r_state <= ST_STOP;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_accept) begin
            w_next_state = ST_LOADING;
        end else begin
            unique case (r_state)
                ST_STOP, ST_RUN, ST_LOADING: w_next_state = run ? ST_RUN : ST_STOP;
                default:                     w_next_state = ST_STOP;
            endcase
        end
    end

    always_comb begin
        w_load_ready_next = (w_next_state != ST_LOADING);
    end

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN) begin
            r_presc      <= '0;
            r_hh         <= '0;
            r_mm         <= '0;
            r_ss         <= '0;
            r_ms         <= '0;
            r_load_ready <= 1'b0;
            r_load_err   <= 1'b0;
            r_ms_tick    <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_load_ready <= w_load_ready_next;
            r_load_err   <= w_reject;
            r_ms_tick    <= w_advance;
            r_wrap       <= w_advance && w_rollover;

            if (clear || w_accept)
                r_presc <= '0;
            else if (r_state == ST_RUN)
                r_presc <= w_tick ? '0 : r_presc + c_PRESC_W'(1);

            if (clear) begin
                r_hh <= '0;
                r_mm <= '0;
                r_ss <= '0;
                r_ms <= '0;
            end else if (w_accept) begin
                r_hh <= load_hh;
                r_mm <= load_mm;
                r_ss <= load_ss;
                r_ms <= '0;
            end else if (w_advance) begin
                r_ms <= w_ms_inc[11:0];
                if (w_c_ms) r_ss <= w_ss_inc[7:0];
                if (w_c_ss) r_mm <= w_mm_inc[7:0];
                if (w_c_mm) r_hh <= w_hh_inc[7:0];
            end
        end
    end

    assign w_digits = {r_hh, r_mm, r_ss, r_ms};

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_seg
            bcd_to_seg7 u_enc (
                .bcd (w_digits[i]),
                .seg (w_con[i*7 +: 7])
            );
        end
    endgenerate

    always_ff @(posedge CLK or negedge RST_BTN) begin
        if (!RST_BTN)
            r_con <= {NUM_DIGITS{GLYPH_TABLE[0]}};
        else
            r_con <= w_con;
    end

    assign load_ready = r_load_ready;
    assign load_err   = r_load_err;
    assign ms_tick    = r_ms_tick;
    assign wrap       = r_wrap;
    assign con        = r_con;

endmodule

`default_nettype wire

// File: tb/tb_clock_seg_driver.sv
// ============================================================================
// Module   : tb_clock_seg_driver
// Brief    : Self-checking bench for clock_seg_driver with a con scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clock_seg_driver;

    logic        CLK = 1'b0;
    logic        RST_BTN = 1'b0;
    logic        run = 1'b0, clear = 1'b0, load_valid = 1'b0;
    logic [7:0]  load_hh = '0, load_mm = '0, load_ss = '0;
    logic        load_ready, load_err, ms_tick, wrap;
    logic [62:0] con;

    int total = 0;
    int bad   = 0;
    int tick_cnt = 0;
    int wrap_cnt = 0;

    typedef struct {
        string       tag;
        logic [62:0] val;
    } exp_t;
    exp_t sb[$];

    clock_seg_driver #(.CLK_HZ(4000), .MS_DIV(4)) dut (
        .CLK        (CLK),
        .RST_BTN    (RST_BTN),
        .run        (run),
        .clear      (clear),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_hh    (load_hh),
        .load_mm    (load_mm),
        .load_ss    (load_ss),
        .load_err   (load_err),
        .ms_tick    (ms_tick),
        .wrap       (wrap),
        .con        (con)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (ms_tick === 1'b1) tick_cnt++;
        if (wrap === 1'b1)    wrap_cnt++;
    end

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: return 7'b0000001;
            4'd1: return 7'b1001111;
            4'd2: return 7'b0010010;
            4'd3: return 7'b0000110;
            4'd4: return 7'b1001100;
            4'd5: return 7'b0100100;
            4'd6: return 7'b0100000;
            4'd7: return 7'b0001111;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [62:0] enc(input logic [7:0] hh, input logic [7:0] mm,
                                        input logic [7:0] ss, input logic [11:0] ms);
        logic [35:0] n;
        logic [62:0] r;
        n = {hh, mm, ss, ms};
        r = '0;
        for (int i = 0; i < 9; i++) r[i*7 +: 7] = glyph(n[i*4 +: 4]);
        return r;
    endfunction

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input logic [62:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            check_value("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check_value(e.tag, {1'b0, con}, {1'b0, e.val});
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cnt;
        bit found;

        // Reset and idle
        step(3);
        push_exp("con_reset", enc(8'h00, 8'h00, 8'h00, 12'h000));
        pop_check();
        check_value("ready_in_reset", {63'd0, load_ready}, 64'd0);
        check_value("tick_in_reset", {63'd0, ms_tick}, 64'd0);
        RST_BTN = 1'b1;
        step(1);
        check_value("ready_after_reset", {63'd0, load_ready}, 64'd1);
        step(100);
        check_value("idle_ticks", 64'(tick_cnt), 64'd0);

        // One second of running
        base = tick_cnt;
        run = 1'b1;
        push_exp("con_1s", enc(8'h00, 8'h00, 8'h01, 12'h000));
        step(4001);
        check_value("final_tick", {63'd0, ms_tick}, 64'd1);
        run = 1'b0;
        step(1);
        check_value("s0_glyph", {57'd0, con[27:21]}, {57'd0, 7'b1001111});
        pop_check();
        check_value("ticks_1s", 64'(tick_cnt - base), 64'd1000);

        // Load 23:59:59 and run into the midnight rollover
        load_valid = 1'b1; load_hh = 8'h23; load_mm = 8'h59; load_ss = 8'h59;
        push_exp("con_load_2359", enc(8'h23, 8'h59, 8'h59, 12'h000));
        step(1);
        check_value("ready_loading", {63'd0, load_ready}, 64'd0);
        load_valid = 1'b0;
        run = 1'b1;
        step(1);
        pop_check();
        base = tick_cnt;
        cnt = wrap_cnt;
        found = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            step(1);
            if (wrap === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        check_value("wrap_seen", {63'd0, found}, 64'd1);
        check_value("wrap_with_tick", {63'd0, ms_tick}, 64'd1);
        run = 1'b0;
        push_exp("con_wrap", enc(8'h00, 8'h00, 8'h00, 12'h000));
        step(1);
        pop_check();
        check_value("ticks_to_wrap", 64'(tick_cnt - base), 64'd1000);
        check_value("wrap_once", 64'(wrap_cnt - cnt), 64'd1);

        // Valid load then two rejected loads
        load_valid = 1'b1; load_hh = 8'h12; load_mm = 8'h34; load_ss = 8'h56;
        step(1);
        load_valid = 1'b0;
        step(1);
        push_exp("con_load_1234", enc(8'h12, 8'h34, 8'h56, 12'h000));
        pop_check();
        load_valid = 1'b1; load_hh = 8'h24;
        step(1);
        check_value("err_hh", {63'd0, load_err}, 64'd1);
        check_value("ready_after_bad_hh", {63'd0, load_ready}, 64'd1);
        load_valid = 1'b0; load_hh = 8'h12;
        step(1);
        check_value("err_hh_pulse", {63'd0, load_err}, 64'd0);
        load_valid = 1'b1; load_mm = 8'h5A;
        step(1);
        check_value("err_mm", {63'd0, load_err}, 64'd1);
        load_valid = 1'b0; load_mm = 8'h34;
        step(1);
        check_value("err_mm_pulse", {63'd0, load_err}, 64'd0);
        push_exp("con_after_bad", enc(8'h12, 8'h34, 8'h56, 12'h000));
        pop_check();

        // clear, load and tick on the same edge
        base = tick_cnt;
        run = 1'b1;
        step(4);
        clear = 1'b1;
        load_valid = 1'b1; load_hh = 8'h01; load_mm = 8'h02; load_ss = 8'h03;
        step(1);
        check_value("clr_no_tick", {63'd0, ms_tick}, 64'd0);
        check_value("clr_no_load", {63'd0, load_ready}, 64'd1);
        check_value("clr_no_err", {63'd0, load_err}, 64'd0);
        clear = 1'b0;
        push_exp("con_cleared", enc(8'h00, 8'h00, 8'h00, 12'h000));
        step(1);
        check_value("reload_taken", {63'd0, load_ready}, 64'd0);
        pop_check();
        load_valid = 1'b0;
        push_exp("con_reload", enc(8'h01, 8'h02, 8'h03, 12'h000));
        step(1);
        pop_check();
        check_value("clr_ticks", 64'(tick_cnt - base), 64'd0);

        // Run to 12:34:56.789 then reset asynchronously
        load_valid = 1'b1; load_hh = 8'h12; load_mm = 8'h34; load_ss = 8'h56;
        step(1);
        load_valid = 1'b0;
        cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            step(1);
            if (ms_tick === 1'b1) cnt++;
            if (cnt == 789) break;
        end
        check_value("ticks_to_789", 64'(cnt), 64'd789);
        push_exp("con_789", enc(8'h12, 8'h34, 8'h56, 12'h789));
        step(1);
        pop_check();
        #2;
        RST_BTN = 1'b0;
        #1;
        push_exp("con_async_reset", enc(8'h00, 8'h00, 8'h00, 12'h000));
        pop_check();
        check_value("ready_async_reset", {63'd0, load_ready}, 64'd0);
        check_value("tick_async_reset", {63'd0, ms_tick}, 64'd0);
        check_value("sb_drained", 64'(sb.size()), 64'd0);

        run = 1'b0;
        step(2);
        RST_BTN = 1'b1;
        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clock_seg_driver.md
Name: clock_seg_driver

Overview:
- Timekeeping core of the multimode clock. Keeps an HH:MM:SS.mmm time in BCD, advancing on a millisecond tick derived from the 100 MHz board clock.
- Encodes the nine digits into the 63-bit active-low segment vector `con` that the VGA display block renders.
- Sits between the mode/button logic (run, clear, set-time handshake) and the display.

Parameters:
- CLK_HZ, 100000000, board clock frequency in Hz.
- MS_DIV, CLK_HZ/1000, clock cycles per millisecond tick. Must be >= 2; benches use 4.

Ports:
- CLK  in  1  board clock; all state on the rising edge.
- RST_BTN  in  1  asynchronous, active-low reset.
- run  in  1  level: 1 = time advances, 0 = time frozen.
- clear  in  1  pulse: zero the time and prescaler.
- load_valid  in  1  set-time request.
- load_ready  out  1  high when a load can be accepted.
- load_hh  in  8  hours, 2 BCD digits.
- load_mm  in  8  minutes, 2 BCD digits.
- load_ss  in  8  seconds, 2 BCD digits.
- load_err  out  1  one-cycle pulse: load rejected.
- ms_tick  out  1  one-cycle pulse at each millisecond advance.
- wrap  out  1  one-cycle pulse on rollover 23:59:59.999 -> 00:00:00.000.
- con  out  63  segment vector.

Behaviour:
- Digit order in `con` (MSB first): H1, H0, M1, M0, S1, S0, ms2, ms1, ms0.
  - Each digit occupies 7 bits, in order a, b, c, d, e, f, g (a = top, clockwise, g = middle).
  - Active-low: 0 = segment lit.
  - H1 occupies con[62:56]; ms0 occupies con[6:0].
- Glyphs:
  - Digits 0-9 use standard seven-segment glyphs; "0" = 7'b0000001.
  - A digit value above 9 encodes as blank, 7'b1111111 (unreachable in normal operation).
- Reset (RST_BTN = 0, asynchronous):
  - all digits 0, prescaler 0, FSM = STOP;
  - load_ready = 0, load_err = 0, ms_tick = 0, wrap = 0;
  - con = {9{7'b0000001}}.
- FSM states:
  - STOP: time frozen; prescaler holds. STOP -> RUN when run = 1.
  - RUN: prescaler counts. RUN -> STOP when run = 0; the prescaler value is retained.
  - LOADING: one-cycle state after an accepted load. Returns next cycle to RUN if run = 1, else STOP.
- Prescaler:
  - In RUN it counts 0 .. MS_DIV-1.
  - When it reaches MS_DIV-1, ms_tick pulses and the time increments on that same edge.
- Increment: BCD ripple with these limits:
  - ms 999 -> 000 carries into seconds;
  - seconds 59 -> 00 carries into minutes;
  - minutes 59 -> 00 carries into hours;
  - hours 23 -> 00 pulses wrap in the same cycle as that ms_tick.
- Load handshake:
  - load_ready = 1 in STOP and RUN, 0 in LOADING and during reset.
  - A transfer occurs on an edge where load_valid & load_ready.
  - Valid load (every nibble <= 9, hh <= 23, mm <= 59, ss <= 59): H/M/S take the load values, ms is set to 000, prescaler to 0, FSM goes to LOADING.
  - Invalid load: time unchanged, load_err pulses for 1 cycle, FSM state unchanged.
  - load_valid may stay high. While high, a new load transfers every other cycle, because LOADING drops ready for one cycle.
- Priority on a single edge: clear > load > tick.
  - clear zeroes the time and prescaler and suppresses a same-cycle tick and load; that load is not consumed. FSM state is unaffected.
  - An accepted load suppresses a same-cycle tick.
- Output latency:
  - con is registered and reflects the digit state one cycle after it changes.
  - After reset deassertion, con keeps its reset value until a digit changes.
- Mid-operation reset aborts any load and returns everything to the reset values immediately.

Decomposition:
- Package clock_pkg holds:
  - the digit-order index constants;
  - the segment bit-position constants SEG_A .. SEG_G;
  - the active-low glyph table for 0-9 and GLYPH_BLANK;
  - the BCD limit constants (HH_MAX = 8'h23, MS_MAX = 12'h999);
  - the FSM state enum.
- One sub-module is natural: bcd_to_seg7, a combinational 4-bit BCD to 7-bit active-low encoder, instantiated 9 times. Registering of `con` stays in the parent.

Test Plan (all with MS_DIV = 4):
- Reset, run = 0: con = {9{7'b0000001}}, load_ready = 0 during reset and 1 after. 100 cycles idle -> no ms_tick.
- run = 1 for 4000 cycles: exactly 1000 ms_ticks; time 00:00:01.000; the S0 field of con = 7'b1001111 (glyph "1") one cycle after the final tick.
- Load 23:59:59 (valid), run = 1, wait 4000 cycles: wrap pulses once on the tick reaching 00:00:00.000; con returns to its all-zero glyphs.
- Load hh = 8'h24, then mm = 8'h5A: load_err pulses 1 cycle each; time and con unchanged; FSM state unchanged.
- clear, load_valid and tick asserted on the same edge: time = 00:00:00.000; no ms_tick; the load is not transferred; re-presented load is accepted the next cycle.
- Assert RST_BTN = 0 mid-run at 12:34:56.789: outputs immediately take reset values asynchronously, with no clock edge required.
